// File: rtl/idct_mac_datapath_if.sv
// Bus between the MPEG control FSM and the IDCT MAC datapath.
// master = FSM side, slave = datapath side.
interface idct_mac_datapath_if #(
  parameter int COEF_W = 12
);
  logic                     Active_MAC;
  logic [2:0]               var_u;
  logic [2:0]               var_v;
  logic [2:0]               var_x;
  logic [2:0]               var_y;
  logic signed [COEF_W-1:0] Coef_Data;
  logic [5:0]               Rd_Addr;
  logic [7:0]               Rd_Data;
  logic                     Pixel_Valid;
  logic [7:0]               Pixel_Out;
  logic [5:0]               Pixel_Addr;
  logic                     Block_Done;

  modport master (
    output Active_MAC, var_u, var_v, var_x, var_y,
    output Coef_Data, Rd_Addr,
    input  Rd_Data, Pixel_Valid, Pixel_Out,
    input  Pixel_Addr, Block_Done
  );

  modport slave (
    input  Active_MAC, var_u, var_v, var_x, var_y,
    input  Coef_Data, Rd_Addr,
    output Rd_Data, Pixel_Valid, Pixel_Out,
    output Pixel_Addr, Block_Done
  );
endinterface

// File: rtl/idct_mac_datapath.sv
// 8x8 inverse-DCT multiply-accumulate pipeline with
// saturating pixel output and a 64-entry frame buffer.
module idct_mac_datapath #(
  parameter int COEF_W = 12,
  parameter int ACC_W  = 36
) (
  input logic Clock,
  input logic Reset,
  idct_mac_datapath_if.slave bus
);
  localparam int T_W = 16;
  localparam int W_W = 18;
  localparam int P_W = COEF_W + W_W;

  // T(k,n) = round(8192*C(n)*cos((2k+1)n*pi/16)); the
  // angle index is folded into one quarter-wave table.
  function automatic logic signed [T_W-1:0] cos_t(
    input logic [2:0] k,
    input logic [2:0] n
  );
    logic [4:0]            m;
    logic [4:0]            f;
    logic                  neg;
    logic [3:0]            j;
    logic signed [T_W-1:0] mag;
    m   = {1'b0, k, 1'b1} * {2'b00, n};
    f   = m[4] ? (~m + 5'd1) : m;
    neg = f > 5'd8;
    j   = neg ? 4'(5'd16 - f) : f[3:0];
    case (j)
      4'd0:    mag = 16'sd8192;
      4'd1:    mag = 16'sd8035;
      4'd2:    mag = 16'sd7568;
      4'd3:    mag = 16'sd6811;
      4'd4:    mag = 16'sd5793;
      4'd5:    mag = 16'sd4551;
      4'd6:    mag = 16'sd3135;
      4'd7:    mag = 16'sd1598;
      default: mag = 16'sd0;
    endcase
    if (n == 3'd0)
      cos_t = 16'sd5793;
    else
      cos_t = neg ? -mag : mag;
  endfunction

  logic                     v0, v1, v2, v3;
  logic signed [COEF_W-1:0] c0, c1;
  logic signed [T_W-1:0]    tx0, ty0;
  logic [5:0]               a0, a1, a2;
  logic                     f0, f1;
  logic                     l0, l1, l2;
  logic signed [W_W-1:0]    w1;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               pix;
  logic [5:0]               paddr;
  logic                     done;
  logic [5:0]               cnt;
  logic [7:0]               buffer [64];
  logic [7:0]               rd;

  logic signed [31:0]       prod;
  logic signed [P_W-1:0]    term;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  sum;
  logic [7:0]               sat;
  logic                     wr;

  assign prod = tx0 * ty0;
  assign term = c1 * w1;
  assign base = f1 ? '0 : acc;
  assign wr   = v2 && l2;

  // Round, level-shift and clamp the finished sum.
  always_comb begin
    rnd = (acc + ACC_W'(8192)) >>> 14;
    sum = rnd + ACC_W'(128);
    sat = '0;
    unique case (1'b1)
      sum < 0:             sat = 8'd0;
      sum > ACC_W'(255):   sat = 8'd255;
      default:             sat = sum[7:0];
    endcase
  end

  // S0: capture the accepted term and look up both cosines.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      v0  <= 1'b0;
      c0  <= '0;
      tx0 <= '0;
      ty0 <= '0;
      a0  <= '0;
      f0  <= 1'b0;
      l0  <= 1'b0;
    end else begin
      v0 <= bus.Active_MAC;
      if (bus.Active_MAC) begin
        c0  <= bus.Coef_Data;
        tx0 <= cos_t(bus.var_x, bus.var_u);
        ty0 <= cos_t(bus.var_y, bus.var_v);
        a0  <= {bus.var_x, bus.var_y};
        f0  <= (bus.var_u == 3'd0) && (bus.var_v == 3'd0);
        l0  <= (bus.var_u == 3'd7) && (bus.var_v == 3'd7);
      end
    end
  end

  // S1: combined 2-D basis weight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      v1 <= 1'b0;
      w1 <= '0;
      c1 <= '0;
      a1 <= '0;
      f1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= v0;
      if (v0) begin
        w1 <= W_W'(prod >>> 14);
        c1 <= c0;
        a1 <= a0;
        f1 <= f0;
        l1 <= l0;
      end
    end
  end

  // S2: accumulate; a first term restarts the sum.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      v2  <= 1'b0;
      acc <= '0;
      a2  <= '0;
      l2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        acc <= base + ACC_W'(term);
        a2  <= a1;
        l2  <= l1;
      end
    end
  end

  // S3: publish the finished pixel and track block count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      v3    <= 1'b0;
      pix   <= '0;
      paddr <= '0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      v3   <= wr;
      done <= 1'b0;
      if (wr) begin
        pix   <= sat;
        paddr <= a2;
        cnt   <= cnt + 6'd1;
        done  <= cnt == 6'd63;
      end
    end
  end

  // Frame buffer with registered read (old data on collision).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 64; i++) buffer[i] <= '0;
      rd <= '0;
    end else begin
      rd <= buffer[bus.Rd_Addr];
      if (wr) buffer[a2] <= sat;
    end
  end

  assign bus.Pixel_Valid = v3;
  assign bus.Pixel_Out   = pix;
  assign bus.Pixel_Addr  = paddr;
  assign bus.Block_Done  = done;
  assign bus.Rd_Data     = rd;
endmodule

// File: tb/tb_idct_mac_datapath.sv
// Randomised bench for idct_mac_datapath against a
// floating-point-derived IDCT reference model.
module tb_idct_mac_datapath;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1;

  idct_mac_datapath_if #(.COEF_W(12)) bus ();

  idct_mac_datapath #(
    .COEF_W(12),
    .ACC_W (36)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int     val;
    int     addr;
    bit     done;
    longint t;
  } exp_t;

  exp_t eq[$];
  exp_t e;
  int   F[8][8];
  int   tab[8][8];
  int   mb[64];
  int   npix;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int tcos(int k, int n);
    real c;
    real r;
    c = (n == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    r = 8192.0 * c * $cos(real'((2 * k + 1) * n) * PI / 16.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(0.5 - r);
  endfunction

  function automatic longint fdiv(longint a, longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int ref_pix(int x, int y);
    longint acc;
    longint p;
    acc = 0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        acc += longint'(F[u][v]) *
               fdiv(longint'(tab[x][u]) * longint'(tab[y][v]), 16384);
    p = fdiv(acc + 8192, 16384) + 128;
    if (p < 0) return 0;
    if (p > 255) return 255;
    return int'(p);
  endfunction

  always @(negedge clk) begin
    if (bus.Pixel_Valid) begin
      if (eq.size() == 0) begin
        chk("extra_pix", 1, 0);
      end else begin
        e = eq.pop_front();
        chk("pix_val", bus.Pixel_Out, e.val);
        chk("pix_addr", bus.Pixel_Addr, e.addr);
        chk("pix_done", bus.Block_Done, e.done);
        chk("pix_time", cyc, e.t);
      end
    end else if (bus.Block_Done) begin
      chk("stray_done", 1, 0);
    end
  end

  task automatic push_pix(input int x, input int y);
    exp_t n;
    n.val  = ref_pix(x, y);
    n.addr = x * 8 + y;
    npix++;
    n.done = (npix == 64);
    if (npix == 64) npix = 0;
    n.t = cyc + 4;
    mb[n.addr] = n.val;
    eq.push_back(n);
  endtask

  task automatic term(input int x, input int y, input int u,
                      input int v, input int c, input bit push);
    @(negedge clk);
    bus.Active_MAC = 1'b1;
    bus.var_x      = x[2:0];
    bus.var_y      = y[2:0];
    bus.var_u      = u[2:0];
    bus.var_v      = v[2:0];
    bus.Coef_Data  = c[11:0];
    if (push && u == 7 && v == 7) push_pix(x, y);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.Active_MAC = 1'b0;
    bus.var_x      = 3'($urandom);
    bus.var_y      = 3'($urandom);
    bus.var_u      = 3'($urandom);
    bus.var_v      = 3'($urandom);
    bus.Coef_Data  = 12'($urandom);
  endtask

  task automatic rb(input int a, input int exp, input string tag);
    @(negedge clk);
    bus.Rd_Addr = a[5:0];
    @(negedge clk);
    chk(tag, bus.Rd_Data, exp);
  endtask

  task automatic run_block(input int gmin, input int gmax);
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int u = 0; u < 8; u++)
          for (int v = 0; v < 8; v++) begin
            term(x, y, u, v, F[u][v], 1'b1);
            if (!(x == 7 && y == 7 && u == 7 && v == 7))
              repeat ($urandom_range(gmax, gmin)) idle();
          end
    for (int i = 1; i <= 8; i++) begin
      idle();
      if (i == 4) bus.Rd_Addr = 6'd63;
      if (i == 5) chk("rd_lat", bus.Rd_Data, mb[63]);
    end
    chk("drain", eq.size(), 0);
    eq.delete();
    for (int a = 0; a < 64; a++) rb(a, mb[a], "buf");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.Active_MAC = 1'b1;
    bus.var_x      = 3'd3;
    bus.var_y      = 3'd3;
    bus.var_u      = 3'd7;
    bus.var_v      = 3'd7;
    bus.Coef_Data  = 12'd500;
    @(negedge clk);
    rst            = 1'b0;
    bus.Active_MAC = 1'b0;
    eq.delete();
    npix = 0;
    for (int a = 0; a < 64; a++) mb[a] = 0;
  endtask

  task automatic clr_f();
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) F[u][v] = 0;
  endtask

  task automatic rand_f();
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        F[u][v] = int'($urandom_range(160, 0)) - 80;
    F[0][0] = int'($urandom_range(2047, 0)) - 1024;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Active_MAC = 1'b0;
    bus.var_x      = '0;
    bus.var_y      = '0;
    bus.var_u      = '0;
    bus.var_v      = '0;
    bus.Coef_Data  = '0;
    bus.Rd_Addr    = '0;
    npix           = 0;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) tab[k][n] = tcos(k, n);
    clr_f();
    do_reset();

    @(negedge clk);
    chk("rst_pv", bus.Pixel_Valid, 0);
    chk("rst_po", bus.Pixel_Out, 0);
    chk("rst_pa", bus.Pixel_Addr, 0);
    chk("rst_bd", bus.Block_Done, 0);
    chk("rst_rd", bus.Rd_Data, 0);
    rb(0, 0, "rst_buf0");
    rb(63, 0, "rst_buf63");

    clr_f();
    run_block(3, 3);
    rb(0, 128, "zero_0");
    rb(63, 128, "zero_63");

    clr_f();
    F[0][0] = 80;
    run_block(1, 3);
    rb(18, 138, "dc80_s");

    run_block(0, 0);
    rb(45, 138, "dc80_b");

    F[0][0] = -1024;
    run_block(0, 0);
    rb(5, 0, "dc_neg");

    F[0][0] = 2047;
    run_block(0, 0);
    rb(9, 255, "dc_sat");

    clr_f();
    F[1][0] = 64;
    run_block(0, 3);
    for (int y = 0; y < 8; y++) begin
      rb(y, 139, "f10_x0");
      rb(56 + y, 117, "f10_x7");
    end

    rand_f();
    for (int i = 0; i < 30; i++)
      term(2, 5, i / 8, i % 8, F[i / 8][i % 8], 1'b0);
    term(2, 5, 7, 7, F[7][7], 1'b0);
    do_reset();
    repeat (8) idle();
    chk("rst_mid_q", eq.size(), 0);
    rb(21, 0, "rst_mid_buf");
    rb(0, 0, "rst_mid_buf0");
    run_block(0, 0);

    rand_f();
    run_block(0, 0);
    rand_f();
    run_block(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idct_mac_datapath.md
# idct_mac_datapath

Arithmetic stage directly downstream of the q3_mpeg control FSM. It consumes that FSM's var_u/var_v/var_x/var_y indices, its Active_MAC pulse and the coefficient word read from coefficient memory. For each pixel (x,y) it accumulates the 64-term 8x8 inverse DCT and writes the level-shifted, saturated 8-bit pixel into an internal 64-entry frame buffer, which is readable through a registered port.

## Interface
- COEF_W, 12: signed DCT coefficient width.
- ACC_W, 36: signed accumulator width.
- Clock  in  1  rising-edge clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high; clears all state listed under Timing.
- Active_MAC  in  1  one accumulate request per high cycle; indices and Coef_Data are valid in that same cycle.
- var_u, var_v, var_x, var_y  in  3 each  term/pixel indices from the FSM.
- Coef_Data  in  COEF_W  signed F(u,v) from coefficient memory.
- Rd_Addr  in  6  frame-buffer read address {x,y}.
- Rd_Data  out  8  buffer[Rd_Addr], registered, 1-cycle latency.
- Pixel_Valid  out  1  one-cycle pulse; Pixel_Out and Pixel_Addr are valid.
- Pixel_Out  out  8  unsigned pixel.
- Pixel_Addr  out  6  {x,y} of Pixel_Out.
- Block_Done  out  1  one-cycle pulse, asserted together with the Pixel_Valid of the 64th pixel since reset or since the last Block_Done.

## Operation
- Cosine ROM (internal constant): T(k,n) = round(8192·C(n)·cos((2k+1)nπ/16)), 16-bit signed. C(0)=1/√2, otherwise 1. Examples: T(k,0)=5793, T(0,1)=8035, T(7,1)=−8035.
- Stage S0 (registered on an Active_MAC cycle):
  - Coef_Data, Tx=T(var_x,var_u), Ty=T(var_y,var_v), {x,y}.
  - first = (u==0 && v==0); last = (u==7 && v==7).
  - valid0 = 1.
- Stage S1: W = (Tx·Ty) >>> 14, 32-bit product, arithmetic shift (floor), 18-bit signed. Coef and flags are delayed alongside.
- Stage S2: acc <= (first ? 0 : acc) + Coef·W, sign-extended to ACC_W. A first term always restarts the sum, even if the previous pixel was incomplete.
- Stage S3, on valid && last:
  - p = ((acc_new + 8192) >>> 14) + 128, saturated to [0,255].
  - Drive Pixel_Out/Pixel_Addr and pulse Pixel_Valid.
  - buffer[{x,y}] <= p.
  - Increment the 6-bit pixel count. Block_Done = 1 when the count wraps 63→0.
- Non-last terms produce no output. Active_MAC low inserts bubbles; pipeline state is held.
- The pipeline is fully pipelined: back-to-back Active_MAC on every cycle must be accepted. The FSM normally pulses it once every 4 cycles.
- No ordering check beyond first/last. Out-of-order indices are not an error. Pixel_Addr is taken from the last term's indices.
- Rd_Data: registered read. On a same-cycle write to Rd_Addr, Rd_Data returns the old value.

## Timing
- Reset values:
  - valid0..valid3 = 0, acc = 0, pixel count = 0.
  - Pixel_Valid = 0, Pixel_Out = 0, Pixel_Addr = 0, Block_Done = 0, Rd_Data = 0.
  - All 64 buffer entries = 0.
- Latency: Active_MAC with last in cycle t → Pixel_Valid high in cycle t+4, and the buffer entry is readable (Rd_Addr applied) in cycle t+4, with data at t+5.
- Pulses (Pixel_Valid, Block_Done) last exactly one cycle.
- Reset mid-pixel: all in-flight terms are discarded and no Pixel_Valid is produced for them. The next pixel starts clean.
- Reset asserted on a cycle with Active_MAC high: reset wins and the term is dropped.
- Accumulator range: 64·2047·2^15 < 2^35, so no overflow at ACC_W=36.

## Test plan
- All coefficients 0 for one full 8x8 (4096 FSM terms) → 64 Pixel_Valid pulses, each Pixel_Out=128; Block_Done once, with pixel {7,7}; buffer all 128.
- F(0,0)=80, rest 0 → every pixel 138. F(0,0)=−1024 → every pixel 0. F(0,0)=2047 → every pixel 255 (saturation).
- F(1,0)=64, rest 0 → pixel (x=0,y) = 139 and pixel (x=7,y) = 117 for all y. Verify via the Rd_Addr readback with 1-cycle latency.
- Active_MAC every cycle, F(0,0)=80 → Pixel_Valid every 64 cycles, first at cycle 63+4 after the first pulse; values identical to the spaced run.
- Reset asserted after 30 terms of pixel {2,5} → no output for that pixel. Restart at (x,y,u,v)=0 → first pixel correct, count restarts, Block_Done after 64 pixels.
- Two consecutive blocks → Block_Done pulses twice, 64 pixels apart. Second-block values overwrite the buffer.
